// File: rtl/compressed_line_packer.sv
// compressed_line_packer
// Gathers variable-length code fragments, one beat of WORDS_PER_BEAT words at a
// time, into a cache-line accumulator (LSB first) while also keeping the raw
// words of the line. When the line closes, it registers either the packed line
// (if it came out shorter than CACHE_LINE) or the raw line.
module compressed_line_packer #(
    parameter  int CACHE_LINE     = 128,
    parameter  int WORD_WIDTH     = 32,
    parameter  int WORDS_PER_BEAT = 2,
    parameter  int MAX_CODE_LEN   = 34,
    localparam int BEAT_W         = WORD_WIDTH * WORDS_PER_BEAT,
    localparam int FRAG_W         = MAX_CODE_LEN * WORDS_PER_BEAT,
    localparam int BEATS          = CACHE_LINE / BEAT_W,
    localparam int LEN_W          = $clog2(CACHE_LINE + FRAG_W + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [FRAG_W-1:0]     i_code,
    input  logic [LEN_W-1:0]      i_code_len,
    input  logic [BEAT_W-1:0]     i_raw,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CACHE_LINE-1:0] o_line,
    output logic [LEN_W-1:0]      o_line_len,
    output logic                  o_compressed_flag,
    output logic                  o_err
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int EXT_W = CACHE_LINE + FRAG_W;

    // Line-building state
    logic [CACHE_LINE-1:0] r_acc;
    logic [LEN_W-1:0]      r_fill;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic                  r_stop;
    logic [CACHE_LINE-1:0] r_raw_buf;

    // Output register
    logic                  r_o_valid;
    logic [CACHE_LINE-1:0] r_o_line;
    logic [LEN_W-1:0]      r_o_line_len;
    logic                  r_o_flag;
    logic                  r_err;

    // Combinational next-state values
    logic                  w_len_over;
    logic [LEN_W-1:0]      w_len_c;
    logic [FRAG_W-1:0]     w_code_m;
    logic [CACHE_LINE-1:0] w_code_sh;
    logic [CACHE_LINE-1:0] w_acc_next;
    logic [LEN_W-1:0]      w_total;
    logic                  w_reach;
    logic [LEN_W-1:0]      w_fill_next;
    logic [CACHE_LINE-1:0] w_raw_next;
    logic                  w_cnt_last;
    logic                  w_closing;
    logic                  w_fire;
    logic                  w_err_set;

    // Length clamp, fragment masking/placement and fill arithmetic
    always_comb begin
        w_len_over = (i_code_len > LEN_W'(FRAG_W));
        if (w_len_over) begin
            w_len_c = LEN_W'(FRAG_W);
        end else begin
            w_len_c = i_code_len;
        end
        // Bits at or above the fragment length are don't-care on the input.
        w_code_m  = i_code & ~({FRAG_W{1'b1}} << w_len_c);
        // Bits pushed past the top of the line simply fall off.
        w_code_sh = CACHE_LINE'(EXT_W'(w_code_m) << r_fill);
        if (r_stop) begin
            w_acc_next = r_acc;
        end else begin
            w_acc_next = r_acc | w_code_sh;
        end
        w_total = r_fill + w_len_c;
        w_reach = (w_total >= LEN_W'(CACHE_LINE));
        if (w_reach) begin
            w_fill_next = LEN_W'(CACHE_LINE);
        end else begin
            w_fill_next = w_total;
        end
    end

    // Raw buffer with the current beat's words inserted at its slot
    always_comb begin
        w_raw_next = r_raw_buf;
        for (int b = 0; b < BEATS; b++) begin
            if (r_beat_cnt == CNT_W'(b)) begin
                w_raw_next[b*BEAT_W +: BEAT_W] = i_raw;
            end else begin
                w_raw_next[b*BEAT_W +: BEAT_W] = r_raw_buf[b*BEAT_W +: BEAT_W];
            end
        end
    end

    // Handshake, line-close detection and protocol-error detection
    always_comb begin
        w_cnt_last = (r_beat_cnt == CNT_W'(BEATS - 1));
        w_closing  = i_last | w_cnt_last;
        // Only a closing beat needs a free output register.
        o_ready    = ~r_o_valid | i_ready | ~w_closing;
        w_fire     = i_valid & o_ready;
        w_err_set  = w_fire & ((i_last & ~w_cnt_last) | (w_cnt_last & ~i_last) | w_len_over);
    end

    // Accumulator, fill, beat counter and raw buffer; cleared when a line closes
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_acc      <= '0;
            r_fill     <= '0;
            r_beat_cnt <= '0;
            r_stop     <= 1'b0;
            r_raw_buf  <= '0;
        end else if (w_fire) begin
            if (w_closing) begin
                // Clearing the raw buffer makes missing words of a short line read as zero.
                r_acc      <= '0;
                r_fill     <= '0;
                r_beat_cnt <= '0;
                r_stop     <= 1'b0;
                r_raw_buf  <= '0;
            end else begin
                r_acc      <= w_acc_next;
                r_fill     <= w_fill_next;
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                r_stop     <= r_stop | w_reach;
                r_raw_buf  <= w_raw_next;
            end
        end else begin
            r_acc      <= r_acc;
            r_fill     <= r_fill;
            r_beat_cnt <= r_beat_cnt;
            r_stop     <= r_stop;
            r_raw_buf  <= r_raw_buf;
        end
    end

    // Output line register: load on a closing beat, drop valid once taken
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_o_valid    <= 1'b0;
            r_o_line     <= '0;
            r_o_line_len <= '0;
            r_o_flag     <= 1'b0;
        end else if (w_fire && w_closing) begin
            r_o_valid <= 1'b1;
            if (w_reach) begin
                // Line did not shrink: send the raw words instead.
                r_o_line     <= w_raw_next;
                r_o_line_len <= LEN_W'(CACHE_LINE);
                r_o_flag     <= 1'b0;
            end else begin
                r_o_line     <= w_acc_next;
                r_o_line_len <= w_total;
                r_o_flag     <= 1'b1;
            end
        end else if (i_ready) begin
            r_o_valid <= 1'b0;
        end else begin
            r_o_valid <= r_o_valid;
        end
    end

    // Sticky protocol error flag
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign o_valid           = r_o_valid;
    assign o_line            = r_o_line;
    assign o_line_len        = r_o_line_len;
    assign o_compressed_flag = r_o_flag;
    assign o_err             = r_err;

endmodule
